rca_nibble_sequencer: RTL and testbench

//  Multi-precision adder front end: accepts WIDTH-bit operands and adds them 4 bits per

---
 rtl/rca_nibble_sequencer_if.sv | 45 ++++
 rtl/rca_nibble_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_rca_nibble_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rca_nibble_sequencer_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// The master side issues operands and accepts results; the slave side is the adder.
interface rca_nibble_sequencer_if #(
  parameter int WIDTH = 16
);
  // Operand request channel
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;

  // Result channel
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             v;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  s,
    input  cout,
    input  v
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output s,
    output cout,
    output v
  );
endinterface

// File: rtl/rca_nibble_sequencer.sv
// Multi-precision adder front end.
// Adds two WIDTH-bit operands four bits per cycle through a single 4-bit
// ripple-carry adder, carrying between cycles through a register.  Operands
// are captured on the input handshake and shifted right one nibble per RUN
// cycle; the sum is assembled by shifting each new nibble in at the top, so
// after WIDTH/4 cycles the full sum sits in place.
// WIDTH must be a multiple of 4 and at least 8.

// 4-bit ripple-carry adder built from full-adder cells.
module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  // Full-adder sum bit.
  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  // Full-adder carry bit (majority of the three inputs).
  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (x & ci) | (y & ci);
  endfunction

  logic [4:0] carry_s;

  // Ripple the carry through the four bit positions.
  always_comb begin
    carry_s    = 5'd0;
    s          = 4'd0;
    carry_s[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]         = fa_sum(a[i], b[i], carry_s[i]);
      carry_s[i+1] = fa_carry(a[i], b[i], carry_s[i]);
    end
    cout = carry_s[4];
  end

endmodule

module rca_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  rca_nibble_sequencer_if.slave bus
);

  localparam int                NIB      = WIDTH / 4;
  localparam int                CNT_W    = $clog2(NIB);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;

  // Operand shift registers: the low nibble is always the one being added.
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;

  // Operand sign bits, kept because the operand registers are shifted away.
  logic             a_msb_r;
  logic             b_msb_r;

  // Result registers driven straight onto the bus.
  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             v_r;
  logic             out_valid_r;

  // Per-cycle control decoded from the state.
  logic             load_s;
  logic             step_s;
  logic             last_s;

  // Nibble adder outputs for the current step.
  logic [3:0]       nib_sum_s;
  logic             nib_cout_s;

  rca4 u_rca4 (
    .a    (a_r[3:0]),
    .b    (b_r[3:0]),
    .cin  (carry_r),
    .s    (nib_sum_s),
    .cout (nib_cout_s)
  );

  // Next-state and step control; IN_VALID only matters in IDLE.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          load_s       = 1'b1;
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          last_s       = 1'b1;
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operand capture on handshake, then shift one nibble per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
    end else if (load_s) begin
      a_r     <= bus.a;
      b_r     <= bus.b;
      carry_r <= bus.cin;
      cnt_r   <= {CNT_W{1'b0}};
      a_msb_r <= bus.a[WIDTH-1];
      b_msb_r <= bus.b[WIDTH-1];
    end else if (step_s) begin
      a_r     <= {4'd0, a_r[WIDTH-1:4]};
      b_r     <= {4'd0, b_r[WIDTH-1:4]};
      carry_r <= nib_cout_s;
      cnt_r   <= cnt_r + CNT_W'(1);
    end else begin
      a_r     <= a_r;
      b_r     <= b_r;
      carry_r <= carry_r;
      cnt_r   <= cnt_r;
    end
  end

  // Sum assembly: each new nibble enters at the top and older ones move down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_r <= {WIDTH{1'b0}};
    end else if (step_s) begin
      s_r <= {nib_sum_s, s_r[WIDTH-1:4]};
    end else begin
      s_r <= s_r;
    end
  end

  // Carry-out and signed overflow are taken from the top nibble's step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cout_r <= 1'b0;
      v_r    <= 1'b0;
    end else if (last_s) begin
      cout_r <= nib_cout_s;
      v_r    <= (a_msb_r == b_msb_r) && (nib_sum_s[3] != a_msb_r);
    end else begin
      cout_r <= cout_r;
      v_r    <= v_r;
    end
  end

  // Result valid mirrors the DONE state, registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (next_state_s == DONE);
    end
  end

  // IN_READY is decoded from the state so it is already high while in reset.
  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.s         = s_r;
  assign bus.cout      = cout_r;
  assign bus.v         = v_r;

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Directed bench for the nibble-serial adder: a 16-bit and an 8-bit instance,
// expected results pushed to a scoreboard at each input handshake and popped
// when the adder presents OUT_VALID.
module tb_rca_nibble_sequencer;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb16[$];
  exp_t sb8[$];
  exp_t held;
  int   lat;

  rca_nibble_sequencer_if #(.WIDTH(16)) if16 ();
  rca_nibble_sequencer_if #(.WIDTH(8))  if8 ();

  rca_nibble_sequencer #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  rca_nibble_sequencer #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b, input logic ci);
    logic [16:0] sum;
    exp_t e;
    sum = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    e.s = sum[15:0];
    e.c = sum[16];
    e.v = (a[15] == b[15]) && (sum[15] != a[15]);
    return e;
  endfunction

  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] sum;
    exp_t e;
    sum = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    e.s = {8'd0, sum[7:0]};
    e.c = sum[8];
    e.v = (a[7] == b[7]) && (sum[7] != a[7]);
    return e;
  endfunction

  // Called at a negedge with the 16-bit adder in IDLE: handshake one request.
  task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic ci, input string tag);
    if16.a        = a;
    if16.b        = b;
    if16.cin      = ci;
    if16.in_valid = 1'b1;
    check({tag, "_in_ready"}, {31'd0, if16.in_ready}, 32'd1);
    @(posedge clk);
    sb16.push_back(model16(a, b, ci));
    @(negedge clk);
    if16.in_valid = 1'b0;
  endtask

  // Wait (bounded) for the result and compare it against the scoreboard.
  task automatic wait16(input string tag);
    exp_t e;
    lat = 0;
    check({tag, "_busy_in_ready"}, {31'd0, if16.in_ready}, 32'd0);
    while (!if16.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_out_valid"}, {31'd0, if16.out_valid}, 32'd1);
    check({tag, "_latency"}, lat, 32'd4);
    if (sb16.size() > 0) begin
      e = sb16.pop_front();
      held = e;
      check({tag, "_s"}, {16'd0, if16.s}, {16'd0, e.s});
      check({tag, "_cout"}, {31'd0, if16.cout}, {31'd0, e.c});
      check({tag, "_v"}, {31'd0, if16.v}, {31'd0, e.v});
    end else begin
      check({tag, "_sb_entries"}, 32'd0, 32'd1);
    end
  endtask

  // Accept the result and confirm return to IDLE.
  task automatic release16(input string tag);
    if16.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if16.out_ready = 1'b0;
    check({tag, "_rel_out_valid"}, {31'd0, if16.out_valid}, 32'd0);
    check({tag, "_rel_in_ready"}, {31'd0, if16.in_ready}, 32'd1);
  endtask

  initial begin
    exp_t e8;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if16.in_valid = 1'b0; if16.a = 16'd0; if16.b = 16'd0; if16.cin = 1'b0; if16.out_ready = 1'b0;
    if8.in_valid  = 1'b0; if8.a  = 8'd0;  if8.b  = 8'd0;  if8.cin  = 1'b0; if8.out_ready  = 1'b0;

    // Reset state
    #1;
    check("rst_in_ready", {31'd0, if16.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, if16.out_valid}, 32'd0);
    check("rst_s", {16'd0, if16.s}, 32'd0);
    check("rst_cout", {31'd0, if16.cout}, 32'd0);
    check("rst_v", {31'd0, if16.v}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed additions
    start16(16'h1234, 16'h4321, 1'b0, "add_5555"); wait16("add_5555"); release16("add_5555");
    start16(16'hFFFF, 16'h0001, 1'b0, "ripple");   wait16("ripple");   release16("ripple");
    start16(16'h7FFF, 16'h0000, 1'b1, "ovf");      wait16("ovf");      release16("ovf");

    // A few random operands
    for (int i = 0; i < 4; i++) begin
      start16(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), "rand");
      wait16("rand");
      release16("rand");
    end

    // Backpressure in DONE with a new request already waiting
    start16(16'h8000, 16'h8000, 1'b0, "bp");
    wait16("bp");
    if16.a        = 16'h0F0F;
    if16.b        = 16'h1010;
    if16.cin      = 1'b1;
    if16.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_s", {16'd0, if16.s}, {16'd0, held.s});
      check("bp_hold_cout", {31'd0, if16.cout}, {31'd0, held.c});
      check("bp_hold_v", {31'd0, if16.v}, {31'd0, held.v});
      check("bp_hold_in_ready", {31'd0, if16.in_ready}, 32'd0);
      check("bp_hold_out_valid", {31'd0, if16.out_valid}, 32'd1);
    end
    if16.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if16.out_ready = 1'b0;
    check("bp_idle_out_valid", {31'd0, if16.out_valid}, 32'd0);
    start16(16'h0F0F, 16'h1010, 1'b1, "bp_next");
    wait16("bp_next");
    release16("bp_next");

    // Reset after the second RUN cycle discards the pending result
    start16(16'hAAAA, 16'h5555, 1'b1, "mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, if16.out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, if16.in_ready}, 32'd1);
    check("mid_rst_s", {16'd0, if16.s}, 32'd0);
    sb16.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start16(16'h0001, 16'h0001, 1'b0, "post_rst"); wait16("post_rst"); release16("post_rst");

    // 8-bit instance: two nibble cycles
    if8.a        = 8'hF0;
    if8.b        = 8'h0F;
    if8.cin      = 1'b1;
    if8.in_valid = 1'b1;
    check("w8_in_ready", {31'd0, if8.in_ready}, 32'd1);
    @(posedge clk);
    sb8.push_back(model8(8'hF0, 8'h0F, 1'b1));
    @(negedge clk);
    if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w8_out_valid", {31'd0, if8.out_valid}, 32'd1);
    check("w8_latency", lat, 32'd2);
    if (sb8.size() > 0) begin
      e8 = sb8.pop_front();
      check("w8_s", {24'd0, if8.s}, {16'd0, e8.s});
      check("w8_cout", {31'd0, if8.cout}, {31'd0, e8.c});
      check("w8_v", {31'd0, if8.v}, {31'd0, e8.v});
    end else begin
      check("w8_sb_entries", 32'd0, 32'd1);
    end
    if8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8.out_ready = 1'b0;
    check("w8_rel_in_ready", {31'd0, if8.in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
